fp_normalizer: RTL and testbench

FP_NORMALIZER -- requirements
Module: fp_normalizer

---
 rtl/fp_pkg.sv | 14 +
 rtl/fp_norm_exp_step.sv | 36 +++
 rtl/fp_normalizer.sv | 150 +++++++++++++++
 tb/tb_fp_normalizer.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared types and default widths for the floating-point normaliser.
// FSM state encoding plus default exponent/mantissa widths.
package fp_pkg;

    localparam int FP_EXP_W  = 8;
    localparam int FP_MANT_W = 28;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } fp_norm_state_t;

endpackage

// File: rtl/fp_norm_exp_step.sv
// Exponent step unit: +1 with all-ones saturation, or -1, plus zero detect.
// o_sat flags an increment that reached or stayed at all-ones.
module fp_norm_exp_step #(
    parameter int EXP_W = 8
) (
    input  logic [EXP_W-1:0] i_exp,
    input  logic             i_dec,
    output logic [EXP_W-1:0] o_exp,
    output logic             o_sat,
    output logic             o_zero
);

    localparam logic [EXP_W-1:0] ALL1 = '1;
    localparam logic [EXP_W-1:0] ONE  = {{(EXP_W-1){1'b0}}, 1'b1};

    logic [EXP_W-1:0] w_inc;
    logic             w_inc_sat;

    assign w_inc     = i_exp + ONE;
    assign w_inc_sat = (i_exp == ALL1) || (w_inc == ALL1);

    // Select decrement or saturating increment.
    always_comb begin
        o_exp = i_exp;
        o_sat = 1'b0;
        if (i_dec) begin
            o_exp = i_exp - ONE;
        end else begin
            o_exp = w_inc_sat ? ALL1 : w_inc;
            o_sat = w_inc_sat;
        end
    end

    assign o_zero = (o_exp == '0);

endmodule

// File: rtl/fp_normalizer.sv
// Multi-cycle mantissa normaliser with valid/ready handshakes.
// Optional macro FP_NORM_STICKY_EN keeps a sticky bit on the right-shift path.
module fp_normalizer
    import fp_pkg::*;
#(
    parameter int EXP_W  = FP_EXP_W,
    parameter int MANT_W = FP_MANT_W
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [EXP_W-1:0]  i_exp,
    input  logic [MANT_W-1:0] i_mant,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [EXP_W-1:0]  o_exp,
    output logic [MANT_W-1:0] o_mant,
    output logic              o_overflow,
    output logic              o_underflow,
    output logic              o_zero
);

    localparam int CB = MANT_W - 1;
    localparam int HB = MANT_W - 2;

    fp_norm_state_t    r_state;
    fp_norm_state_t    w_state_nxt;
    logic [EXP_W-1:0]  r_exp;
    logic [EXP_W-1:0]  w_exp_nxt;
    logic [MANT_W-1:0] r_mant;
    logic [MANT_W-1:0] w_mant_nxt;
    logic              r_ovf;
    logic              r_udf;
    logic              r_zero;
    logic              w_ovf_nxt;
    logic              w_udf_nxt;
    logic              w_zero_nxt;

    logic              w_in_shift;
    logic [EXP_W-1:0]  w_step_in;
    logic [EXP_W-1:0]  w_step_exp;
    logic              w_step_sat;
    logic              w_step_zero;
    logic [MANT_W-1:0] w_shr;
    logic [MANT_W-1:0] w_shl;

    // One step unit: increments the incoming exponent while idle,
    // decrements the held exponent while shifting left.
    assign w_in_shift = (r_state == SHIFT);
    assign w_step_in  = w_in_shift ? r_exp : i_exp;

    fp_norm_exp_step #(
        .EXP_W (EXP_W)
    ) u_exp_step (
        .i_exp  (w_step_in),
        .i_dec  (w_in_shift),
        .o_exp  (w_step_exp),
        .o_sat  (w_step_sat),
        .o_zero (w_step_zero)
    );

`ifdef FP_NORM_STICKY_EN
    assign w_shr = {1'b0, i_mant[CB:2], i_mant[1] | i_mant[0]};
`else
    assign w_shr = {1'b0, i_mant[CB:1]};
`endif

    assign w_shl = {r_mant[MANT_W-2:0], 1'b0};

    // Next-state and datapath update for the normalise sequence.
    always_comb begin
        w_state_nxt = r_state;
        w_exp_nxt   = r_exp;
        w_mant_nxt  = r_mant;
        w_ovf_nxt   = r_ovf;
        w_udf_nxt   = r_udf;
        w_zero_nxt  = r_zero;
        unique case (r_state)
            IDLE: begin
                if (i_valid) begin
                    w_ovf_nxt  = 1'b0;
                    w_udf_nxt  = 1'b0;
                    w_zero_nxt = 1'b0;
                    w_exp_nxt  = i_exp;
                    w_mant_nxt = i_mant;
                    w_state_nxt = DONE;
                    if (i_mant == '0) begin
                        w_exp_nxt  = '0;
                        w_zero_nxt = 1'b1;
                    end else if (i_mant[CB]) begin
                        w_mant_nxt = w_shr;
                        w_exp_nxt  = w_step_exp;
                        w_ovf_nxt  = w_step_sat;
                    end else if (i_mant[HB]) begin
                        w_state_nxt = DONE;
                    end else if (i_exp == '0) begin
                        w_udf_nxt = 1'b1;
                    end else begin
                        w_state_nxt = SHIFT;
                    end
                end
            end
            SHIFT: begin
                w_mant_nxt = w_shl;
                w_exp_nxt  = w_step_exp;
                if (w_shl[HB] || w_step_zero) begin
                    w_state_nxt = DONE;
                    w_udf_nxt   = ~w_shl[HB];
                end
            end
            DONE: begin
                if (i_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State and result registers; reset discards any result in flight.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_exp   <= '0;
            r_mant  <= '0;
            r_ovf   <= 1'b0;
            r_udf   <= 1'b0;
            r_zero  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_exp   <= w_exp_nxt;
            r_mant  <= w_mant_nxt;
            r_ovf   <= w_ovf_nxt;
            r_udf   <= w_udf_nxt;
            r_zero  <= w_zero_nxt;
        end
    end

    assign o_ready     = (r_state == IDLE) && !i_rst;
    assign o_valid     = (r_state == DONE) && !i_rst;
    assign o_exp       = r_exp;
    assign o_mant      = r_mant;
    assign o_overflow  = r_ovf  & o_valid;
    assign o_underflow = r_udf  & o_valid;
    assign o_zero      = r_zero & o_valid;

endmodule

// File: tb/tb_fp_normalizer.sv
// Scoreboard bench for fp_normalizer with directed vectors.
// Expected results and latencies are hand-computed per vector.
module tb_fp_normalizer;

    logic        clk;
    logic        i_rst;
    logic        i_valid;
    logic        o_ready;
    logic [7:0]  i_exp;
    logic [27:0] i_mant;
    logic        o_valid;
    logic        i_ready;
    logic [7:0]  o_exp;
    logic [27:0] o_mant;
    logic        o_overflow;
    logic        o_underflow;
    logic        o_zero;

    fp_normalizer #(
        .EXP_W  (8),
        .MANT_W (28)
    ) dut (
        .i_clk       (clk),
        .i_rst       (i_rst),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_exp       (i_exp),
        .i_mant      (i_mant),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_exp       (o_exp),
        .o_mant      (o_mant),
        .o_overflow  (o_overflow),
        .o_underflow (o_underflow),
        .o_zero      (o_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string       name;
        logic [7:0]  e;
        logic [27:0] m;
        logic        ov;
        logic        un;
        logic        zr;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sb[$];
    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h want %0h", nm, act, req);
    endtask

    // Monitor: pop and compare on the first cycle of each o_valid,
    // then check the held outputs stay stable while stalled.
    exp_t        cur;
    logic        seen = 1'b0;
    logic [38:0] held;

    always @(negedge clk) begin
        if (!o_valid) begin
            seen = 1'b0;
        end else if (!seen) begin
            seen = 1'b1;
            held = {o_exp, o_mant, o_overflow, o_underflow, o_zero};
            if (sb.size() == 0) begin
                chk("unexpected_valid", 64'd1, 64'd0);
            end else begin
                cur = sb.pop_front();
                chk({cur.name, "_mant"}, 64'(o_mant), 64'(cur.m));
                chk({cur.name, "_exp"}, 64'(o_exp), 64'(cur.e));
                chk({cur.name, "_flags"},
                    64'({o_overflow, o_underflow, o_zero}),
                    64'({cur.ov, cur.un, cur.zr}));
                chk({cur.name, "_lat"}, 64'(cyc - cur.acc + 1),
                    64'(cur.lat));
            end
        end else begin
            chk("hold_stable",
                64'({o_exp, o_mant, o_overflow, o_underflow, o_zero}),
                64'(held));
            chk("hold_ready", 64'(o_ready), 64'd0);
        end
    end

    task automatic send(input string nm, input logic [7:0] e,
                        input logic [27:0] m, input logic [7:0] qe,
                        input logic [27:0] qm, input logic qo,
                        input logic qu, input logic qz,
                        input int lat, input bit push);
        exp_t x;
        int t = 0;
        @(negedge clk);
        while (!o_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!o_ready) begin
            chk({nm, "_ready_timeout"}, 64'd0, 64'd1);
            return;
        end
        i_exp   = e;
        i_mant  = m;
        i_valid = 1'b1;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        if (push) begin
            x.name = nm; x.e = qe; x.m = qm;
            x.ov = qo; x.un = qu; x.zr = qz;
            x.lat = lat; x.acc = cyc;
            sb.push_back(x);
        end
    endtask

    task automatic drain(input string nm);
        int t = 0;
        while ((sb.size() != 0 || o_valid) && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (sb.size() != 0 || o_valid)
            chk({nm, "_drain_timeout"}, 64'd0, 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin
        int t;
        i_rst   = 1'b1;
        i_valid = 1'b0;
        i_ready = 1'b1;
        i_exp   = '0;
        i_mant  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 64'(o_ready), 64'd0);
        chk("rst_valid", 64'(o_valid), 64'd0);
        i_rst = 1'b0;
        #1;
        chk("post_rst_ready", 64'(o_ready), 64'd1);
        chk("post_rst_out", 64'({o_exp, o_mant}), 64'd0);

        send("carry", 8'd10, 28'h8000000, 8'd11, 28'h4000000,
             0, 0, 0, 1, 1);
        drain("carry");
        send("lshift4", 8'd20, 28'h0400000, 8'd16, 28'h4000000,
             0, 0, 0, 5, 1);
        drain("lshift4");
        send("uflow_shift", 8'd3, 28'h0000001, 8'd0, 28'h0000008,
             0, 1, 0, 4, 1);
        drain("uflow_shift");
        send("ovf_fe", 8'hFE, 28'h8000000, 8'hFF, 28'h4000000,
             1, 0, 0, 1, 1);
        drain("ovf_fe");
        send("ovf_ff", 8'hFF, 28'h8000000, 8'hFF, 28'h4000000,
             1, 0, 0, 1, 1);
        drain("ovf_ff");
        send("no_ovf_fd", 8'hFD, 28'h8000000, 8'hFE, 28'h4000000,
             0, 0, 0, 1, 1);
        drain("no_ovf_fd");
`ifdef FP_NORM_STICKY_EN
        send("sticky", 8'd5, 28'h8000001, 8'd6, 28'h4000001,
             0, 0, 0, 1, 1);
`else
        send("sticky", 8'd5, 28'h8000001, 8'd6, 28'h4000000,
             0, 0, 0, 1, 1);
`endif
        drain("sticky");
        send("zero", 8'd55, 28'h0000000, 8'd0, 28'h0000000,
             0, 0, 1, 1, 1);
        drain("zero");
        send("hidden", 8'd9, 28'h4000123, 8'd9, 28'h4000123,
             0, 0, 0, 1, 1);
        drain("hidden");
        send("exp0", 8'd0, 28'h0000100, 8'd0, 28'h0000100,
             0, 1, 0, 1, 1);
        drain("exp0");
        send("hid_at_exp0", 8'd1, 28'h2000000, 8'd0, 28'h4000000,
             0, 0, 0, 2, 1);
        drain("hid_at_exp0");
        send("max_shift", 8'd200, 28'h0000001, 8'd174, 28'h4000000,
             0, 0, 0, 27, 1);
        drain("max_shift");

        i_ready = 1'b0;
        send("stall", 8'd20, 28'h0400000, 8'd16, 28'h4000000,
             0, 0, 0, 5, 1);
        t = 0;
        while (!o_valid && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("stall_valid", 64'(o_valid), 64'd1);
        repeat (3) @(negedge clk);
        i_ready = 1'b1;
        drain("stall");

        send("abort", 8'd200, 28'h0000001, 8'd0, 28'h0,
             0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        i_rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("abort_valid", 64'(o_valid), 64'd0);
        chk("abort_ready", 64'(o_ready), 64'd0);
        chk("abort_out", 64'({o_exp, o_mant}), 64'd0);
        chk("abort_flags",
            64'({o_overflow, o_underflow, o_zero}), 64'd0);
        i_rst = 1'b0;
        #1;
        chk("abort_ready_after", 64'(o_ready), 64'd1);
        send("after_abort", 8'd20, 28'h0400000, 8'd16, 28'h4000000,
             0, 0, 0, 5, 1);
        drain("after_abort");

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
